dma_ring_scheduler: RTL and testbench

- Command sequencer for the SDRAM capture DMA: divides an SDRAM region into a ring of equal buffers and issues one DMA command per buffer.
- Counts DMA completions, presents filled buffers to the host/readout side, and recycles a buffer slot only after the host acknowledges it.
- Sits between the control registers and the DMA (command FIFO + data FIFO) in the DMA clock domain.

---
 rtl/dma_ring_scheduler.sv | 230 +++++++++++++++++++++++
 tb/tb_dma_ring_scheduler.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_ring_scheduler.sv
// Ring-buffer DMA command sequencer: issues one DMA command per buffer slot,
// absorbs DMA completions and recycles slots after the host acknowledges them.
`timescale 1ns/1ps

module dma_ring_scheduler #(
    parameter int NBUF_MAX = 16,
    parameter int IDX_W    = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             ENABLE,
    input  logic [27:0]      BASE_ADR,
    input  logic [27:0]      BUF_SIZE,
    input  logic [IDX_W:0]   NUM_BUFS,
    input  logic             DATA_AFULL,
    output logic             DMA_START,
    output logic [27:0]      DMA_START_ADR,
    output logic [27:0]      DMA_BUF_SIZE,
    input  logic [15:0]      DMA_DONE_CNT,
    input  logic             DMA_CMD_AEMPTY,
    output logic             BUF_VALID,
    output logic [IDX_W-1:0] BUF_IDX,
    output logic [27:0]      BUF_ADR,
    input  logic             BUF_ACK,
    output logic             BUSY,
    output logic             OVERFLOW
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam logic [IDX_W:0]   NB_MAX  = (IDX_W+1)'(NBUF_MAX);
    localparam logic [IDX_W:0]   CNT_ONE = (IDX_W+1)'(1);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

    // Session configuration
    logic [1:0]       r_state;
    logic             r_enable_d;
    logic [27:0]      r_base;
    logic [27:0]      r_size;
    logic [IDX_W:0]   r_nb;

    // Write (issue) side
    logic [IDX_W-1:0] r_wr_idx;
    logic [27:0]      r_wr_adr;
    logic [IDX_W:0]   r_issued;

    // Completion side
    logic [15:0]      r_shadow;
    logic [IDX_W:0]   r_done;

    // Read (host) side
    logic [IDX_W-1:0] r_rd_idx;
    logic [27:0]      r_rd_adr;
    logic [IDX_W:0]   r_acked;

    // Registered outputs
    logic             r_dma_start;
    logic [27:0]      r_dma_start_adr;
    logic [27:0]      r_dma_buf_size;
    logic             r_overflow;

    logic [1:0]       w_state_nxt;
    logic [IDX_W:0]   w_nb_clamped;
    logic [IDX_W:0]   w_inflight;
    logic             w_start_session;
    logic             w_issue;
    logic             w_absorb;
    logic             w_buf_valid;
    logic             w_ack;
    logic             w_wr_wrap;
    logic             w_rd_wrap;
    logic             w_busy;

    always_comb begin
        if (NUM_BUFS == '0) begin
            w_nb_clamped = CNT_ONE;
        end else if (NUM_BUFS > NB_MAX) begin
            w_nb_clamped = NB_MAX;
        end else begin
            w_nb_clamped = NUM_BUFS;
        end
    end

    // Counters wrap one bit wider than the index, so issued-acked is exact up to nb.
    assign w_inflight      = r_issued - r_acked;
    assign w_busy          = (r_state != S_IDLE);
    assign w_start_session = (r_state == S_IDLE) && ENABLE && !r_enable_d;
    assign w_issue         = (r_state == S_RUN) && ENABLE && DMA_CMD_AEMPTY
                             && (w_inflight < r_nb);
    assign w_absorb        = w_busy && (r_shadow != DMA_DONE_CNT);
    assign w_buf_valid     = (r_done != r_acked);
    assign w_ack           = BUF_ACK && w_buf_valid;
    assign w_wr_wrap       = ({1'b0, r_wr_idx} == (r_nb - CNT_ONE));
    assign w_rd_wrap       = ({1'b0, r_rd_idx} == (r_nb - CNT_ONE));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start_session) w_state_nxt = S_RUN;
            S_RUN: begin
                if (!ENABLE) begin
                    w_state_nxt = S_DRAIN;
                end else if (w_issue) begin
                    w_state_nxt = S_GAP;
                end
            end
            S_GAP:   w_state_nxt = S_RUN;
            S_DRAIN: if (r_done == r_issued) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every always_ff
    // sees the pre-edge values of the others, regardless of evaluation order.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state    <= S_IDLE;
            r_enable_d <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_enable_d <= ENABLE;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_base <= '0;
            r_size <= '0;
            r_nb   <= '0;
        end else if (w_start_session) begin
            r_base <= BASE_ADR;
            r_size <= BUF_SIZE;
            r_nb   <= w_nb_clamped;
        end
    end

    // Address of slot k is accumulated: +size per step, reload base on wrap.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wr_idx <= '0;
            r_wr_adr <= '0;
            r_issued <= '0;
        end else if (w_start_session) begin
            r_wr_idx <= '0;
            r_wr_adr <= BASE_ADR;
            r_issued <= '0;
        end else if (w_issue) begin
            r_issued <= r_issued + CNT_ONE;
            if (w_wr_wrap) begin
                r_wr_idx <= '0;
                r_wr_adr <= r_base;
            end else begin
                r_wr_idx <= r_wr_idx + IDX_ONE;
                r_wr_adr <= r_wr_adr + r_size;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_dma_start     <= 1'b0;
            r_dma_start_adr <= '0;
            r_dma_buf_size  <= '0;
        end else begin
            r_dma_start <= w_issue;
            if (w_issue) begin
                r_dma_start_adr <= r_wr_adr;
                r_dma_buf_size  <= r_size;
            end
        end
    end

    // One completion absorbed per cycle; a jump in DMA_DONE_CNT drains over time.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_shadow <= '0;
            r_done   <= '0;
        end else if (w_start_session) begin
            r_shadow <= DMA_DONE_CNT;
            r_done   <= '0;
        end else if (w_absorb) begin
            r_shadow <= r_shadow + 16'd1;
            r_done   <= r_done + CNT_ONE;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_rd_idx <= '0;
            r_rd_adr <= '0;
            r_acked  <= '0;
        end else if (w_start_session) begin
            r_rd_idx <= '0;
            r_rd_adr <= BASE_ADR;
            r_acked  <= '0;
        end else if (w_ack) begin
            r_acked <= r_acked + CNT_ONE;
            if (w_rd_wrap) begin
                r_rd_idx <= '0;
                r_rd_adr <= r_base;
            end else begin
                r_rd_idx <= r_rd_idx + IDX_ONE;
                r_rd_adr <= r_rd_adr + r_size;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_overflow <= 1'b0;
        end else if (w_start_session) begin
            r_overflow <= 1'b0;
        end else if (w_busy && (w_inflight == r_nb) && DATA_AFULL) begin
            r_overflow <= 1'b1;
        end
    end

    assign DMA_START     = r_dma_start;
    assign DMA_START_ADR = r_dma_start_adr;
    assign DMA_BUF_SIZE  = r_dma_buf_size;
    assign BUF_VALID     = w_buf_valid;
    assign BUF_IDX       = r_rd_idx;
    assign BUF_ADR       = r_rd_adr;
    assign BUSY          = w_busy;
    assign OVERFLOW      = r_overflow;

endmodule

// File: tb/tb_dma_ring_scheduler.sv
// Scoreboard bench for dma_ring_scheduler: expected command addresses are queued
// when a session is configured and popped as DMA_START pulses appear.
`timescale 1ns/1ps

module tb_dma_ring_scheduler;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        ENABLE = 1'b0;
    logic [27:0] BASE_ADR = '0;
    logic [27:0] BUF_SIZE = '0;
    logic [4:0]  NUM_BUFS = '0;
    logic        DATA_AFULL = 1'b0;
    logic [15:0] DMA_DONE_CNT = '0;
    logic        DMA_CMD_AEMPTY = 1'b1;
    logic        BUF_ACK = 1'b0;

    logic        DMA_START;
    logic [27:0] DMA_START_ADR;
    logic [27:0] DMA_BUF_SIZE;
    logic        BUF_VALID;
    logic [3:0]  BUF_IDX;
    logic [27:0] BUF_ADR;
    logic        BUSY;
    logic        OVERFLOW;

    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          n_starts = 0;
    int          last_start = -100;
    logic [27:0] cur_size = '0;
    logic [27:0] exp_q[$];

    dma_ring_scheduler #(.NBUF_MAX(16), .IDX_W(4)) dut (
        .CLK            (CLK),
        .RST_N          (RST_N),
        .ENABLE         (ENABLE),
        .BASE_ADR       (BASE_ADR),
        .BUF_SIZE       (BUF_SIZE),
        .NUM_BUFS       (NUM_BUFS),
        .DATA_AFULL     (DATA_AFULL),
        .DMA_START      (DMA_START),
        .DMA_START_ADR  (DMA_START_ADR),
        .DMA_BUF_SIZE   (DMA_BUF_SIZE),
        .DMA_DONE_CNT   (DMA_DONE_CNT),
        .DMA_CMD_AEMPTY (DMA_CMD_AEMPTY),
        .BUF_VALID      (BUF_VALID),
        .BUF_IDX        (BUF_IDX),
        .BUF_ADR        (BUF_ADR),
        .BUF_ACK        (BUF_ACK),
        .BUSY           (BUSY),
        .OVERFLOW       (OVERFLOW)
    );

    always #5 CLK = ~CLK;

    // Advance to the next falling edge, score any command pulse, then drive
    // the host/DMA responses for the following rising edge.
    task automatic step(input bit auto_done, input bit auto_ack);
        logic [27:0] e;
        @(negedge CLK);
        cyc++;
        if (DMA_START === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_start: got adr=%h, none expected (cycle %0d)", DMA_START_ADR, cyc);
            end else begin
                e = exp_q.pop_front();
                if (DMA_START_ADR !== e || DMA_BUF_SIZE !== cur_size) begin
                    n_fail++;
                    $display("FAIL start_cmd: got adr=%h size=%h, expected adr=%h size=%h",
                             DMA_START_ADR, DMA_BUF_SIZE, e, cur_size);
                end
            end
            if (n_starts > 0) begin
                n_tests++;
                if (cyc - last_start < 2) begin
                    n_fail++;
                    $display("FAIL start_spacing: got %0d cycles, expected >= 2", cyc - last_start);
                end
            end
            last_start = cyc;
            n_starts++;
            if (auto_done) DMA_DONE_CNT = DMA_DONE_CNT + 16'd1;
        end
        BUF_ACK = auto_ack ? BUF_VALID : 1'b0;
    endtask

    task automatic start_session(input logic [27:0] base, input logic [27:0] size,
                                 input logic [4:0] nb);
        BASE_ADR = base;
        BUF_SIZE = size;
        NUM_BUFS = nb;
        cur_size = size;
        ENABLE   = 1'b1;
    endtask

    task automatic wait_idle(input bit auto_done, input bit auto_ack);
        for (int i = 0; i < 100; i++) begin
            step(auto_done, auto_ack);
            if (BUSY === 1'b0) break;
        end
        n_tests++;
        if (BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_timeout: got BUSY=%b, expected 0", BUSY);
        end
    endtask

    task automatic test_reset();
        #2;
        n_tests++;
        if ({DMA_START, DMA_START_ADR, DMA_BUF_SIZE, BUF_VALID, BUF_IDX, BUF_ADR, BUSY, OVERFLOW} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got start=%b adr=%h size=%h valid=%b idx=%h badr=%h busy=%b ovf=%b, expected all 0",
                     DMA_START, DMA_START_ADR, DMA_BUF_SIZE, BUF_VALID, BUF_IDX, BUF_ADR, BUSY, OVERFLOW);
        end
        repeat (3) step(0, 0);
        RST_N = 1'b1;
        repeat (5) step(0, 0);
        n_tests++;
        if (BUSY !== 1'b0 || n_starts !== 0) begin
            n_fail++;
            $display("FAIL reset_idle: got BUSY=%b starts=%0d, expected 0 and 0", BUSY, n_starts);
        end
    endtask

    task automatic test_basic_ring();
        int base_n = n_starts;
        exp_q.push_back(28'h0001000);
        exp_q.push_back(28'h0001100);
        exp_q.push_back(28'h0001200);
        exp_q.push_back(28'h0001300);
        exp_q.push_back(28'h0001000);
        start_session(28'h0001000, 28'h100, 5'd4);
        for (int i = 0; i < 100; i++) begin
            step(1, 1);
            if (n_starts - base_n >= 5) break;
        end
        ENABLE = 1'b0;
        n_tests++;
        if (n_starts - base_n !== 5) begin
            n_fail++;
            $display("FAIL basic_start_count: got %0d, expected 5", n_starts - base_n);
        end
        wait_idle(1, 1);
        repeat (4) step(1, 1);
        n_tests++;
        if (BUF_VALID !== 1'b0 || exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL basic_drained: got valid=%b pending=%0d, expected 0 and 0", BUF_VALID, exp_q.size());
        end
    endtask

    task automatic test_ring_full();
        int base_n = n_starts;
        int ack_cyc;
        for (int k = 0; k < 4; k++) exp_q.push_back(28'h0001000 + 28'(k) * 28'h100);
        start_session(28'h0001000, 28'h100, 5'd4);
        repeat (40) step(1, 0);
        n_tests++;
        if (n_starts - base_n !== 4) begin
            n_fail++;
            $display("FAIL full_start_count: got %0d, expected 4", n_starts - base_n);
        end
        n_tests++;
        if (BUF_VALID !== 1'b1 || BUF_IDX !== 4'd0 || BUF_ADR !== 28'h0001000) begin
            n_fail++;
            $display("FAIL full_head: got valid=%b idx=%0d adr=%h, expected 1 0 0001000", BUF_VALID, BUF_IDX, BUF_ADR);
        end
        n_tests++;
        if (OVERFLOW !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_quiet: got %b, expected 0", OVERFLOW);
        end
        DATA_AFULL = 1'b1;
        step(1, 0);
        DATA_AFULL = 1'b0;
        step(1, 0);
        n_tests++;
        if (OVERFLOW !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_set: got %b, expected 1", OVERFLOW);
        end
        repeat (5) step(1, 0);
        n_tests++;
        if (OVERFLOW !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_sticky: got %b, expected 1", OVERFLOW);
        end
        exp_q.push_back(28'h0001000);
        BUF_ACK = 1'b1;
        ack_cyc = cyc;
        step(1, 0);
        for (int i = 0; i < 10; i++) begin
            if (n_starts - base_n >= 5) break;
            step(1, 0);
        end
        n_tests++;
        if (n_starts - base_n !== 5 || last_start < ack_cyc + 2) begin
            n_fail++;
            $display("FAIL full_reuse: got starts=%0d at cycle %0d, expected 5 at cycle >= %0d",
                     n_starts - base_n, last_start, ack_cyc + 2);
        end
        n_tests++;
        if (BUF_IDX !== 4'd1 || BUF_ADR !== 28'h0001100) begin
            n_fail++;
            $display("FAIL full_ack_advance: got idx=%0d adr=%h, expected 1 0001100", BUF_IDX, BUF_ADR);
        end
        ENABLE = 1'b0;
        wait_idle(1, 0);
        step(0, 0);
        DMA_CMD_AEMPTY = 1'b0;
        start_session(28'h0001000, 28'h100, 5'd4);
        step(0, 0);
        step(0, 0);
        n_tests++;
        if (OVERFLOW !== 1'b0 || BUF_VALID !== 1'b0) begin
            n_fail++;
            $display("FAIL new_session_clear: got ovf=%b valid=%b, expected 0 0", OVERFLOW, BUF_VALID);
        end
        ENABLE = 1'b0;
        DMA_CMD_AEMPTY = 1'b1;
        wait_idle(0, 0);
    endtask

    task automatic test_wrap_burst();
        int base_n = n_starts;
        logic exp_busy;
        logic [27:0] exp_adr;
        step(0, 0);
        DMA_DONE_CNT = 16'hFFFE;
        for (int k = 0; k < 3; k++) exp_q.push_back(28'h0002000 + 28'(k) * 28'h40);
        start_session(28'h0002000, 28'h40, 5'd4);
        for (int i = 0; i < 50; i++) begin
            step(0, 0);
            if (n_starts - base_n >= 3) break;
        end
        ENABLE = 1'b0;
        repeat (4) step(0, 0);
        n_tests++;
        if (BUSY !== 1'b1 || n_starts - base_n !== 3) begin
            n_fail++;
            $display("FAIL burst_pre_drain: got busy=%b starts=%0d, expected 1 3", BUSY, n_starts - base_n);
        end
        DMA_DONE_CNT = DMA_DONE_CNT + 16'd3;
        for (int k = 0; k < 4; k++) begin
            step(0, 0);
            exp_busy = (k < 3);
            n_tests++;
            if (BUSY !== exp_busy) begin
                n_fail++;
                $display("FAIL burst_absorb_rate: cycle %0d after jump got BUSY=%b, expected %b", k + 1, BUSY, exp_busy);
            end
        end
        for (int k = 0; k < 3; k++) begin
            exp_adr = 28'h0002000 + 28'(k) * 28'h40;
            n_tests++;
            if (BUF_VALID !== 1'b1 || BUF_IDX !== 4'(k) || BUF_ADR !== exp_adr) begin
                n_fail++;
                $display("FAIL burst_host_seq: got valid=%b idx=%0d adr=%h, expected 1 %0d %h",
                         BUF_VALID, BUF_IDX, BUF_ADR, k, exp_adr);
            end
            BUF_ACK = 1'b1;
            step(0, 0);
        end
        n_tests++;
        if (BUF_VALID !== 1'b0) begin
            n_fail++;
            $display("FAIL burst_emptied: got valid=%b, expected 0", BUF_VALID);
        end
    endtask

    task automatic test_clamp_drain();
        int base_n = n_starts;
        bit busy_dropped = 1'b0;
        repeat (3) exp_q.push_back(28'h0003000);
        start_session(28'h0003000, 28'h80, 5'd0);
        for (int i = 0; i < 100; i++) begin
            step(n_starts - base_n < 2, 1);
            if (n_starts - base_n >= 3) break;
        end
        ENABLE = 1'b0;
        n_tests++;
        if (n_starts - base_n !== 3) begin
            n_fail++;
            $display("FAIL clamp_low_starts: got %0d, expected 3", n_starts - base_n);
        end
        for (int i = 0; i < 10; i++) begin
            step(0, 1);
            if (BUSY !== 1'b1) busy_dropped = 1'b1;
        end
        n_tests++;
        if (busy_dropped) begin
            n_fail++;
            $display("FAIL drain_hold: got BUSY=0 with a command outstanding, expected 1");
        end
        DMA_DONE_CNT = DMA_DONE_CNT + 16'd1;
        wait_idle(0, 1);

        base_n = n_starts;
        for (int k = 0; k < 16; k++) exp_q.push_back(28'hFFFFF00 + 28'(k) * 28'h20);
        step(0, 0);
        start_session(28'hFFFFF00, 28'h20, 5'd31);
        repeat (60) step(1, 0);
        n_tests++;
        if (n_starts - base_n !== 16) begin
            n_fail++;
            $display("FAIL clamp_high_starts: got %0d, expected 16", n_starts - base_n);
        end
        ENABLE = 1'b0;
        wait_idle(1, 0);
    endtask

    task automatic test_async_reset();
        int base_n = n_starts;
        step(0, 0);
        exp_q.push_back(28'h0001000);
        exp_q.push_back(28'h0001100);
        start_session(28'h0001000, 28'h100, 5'd4);
        for (int i = 0; i < 50; i++) begin
            step(0, 0);
            if (n_starts - base_n >= 2) break;
        end
        RST_N  = 1'b0;
        ENABLE = 1'b0;
        #1;
        n_tests++;
        if ({DMA_START, DMA_START_ADR, DMA_BUF_SIZE, BUF_VALID, BUF_IDX, BUF_ADR, BUSY, OVERFLOW} !== '0) begin
            n_fail++;
            $display("FAIL async_reset_outputs: got start=%b adr=%h size=%h valid=%b idx=%h badr=%h busy=%b ovf=%b, expected all 0",
                     DMA_START, DMA_START_ADR, DMA_BUF_SIZE, BUF_VALID, BUF_IDX, BUF_ADR, BUSY, OVERFLOW);
        end
        repeat (2) step(0, 0);
        RST_N = 1'b1;
        base_n = n_starts;
        repeat (10) step(0, 0);
        n_tests++;
        if (BUSY !== 1'b0 || n_starts !== base_n) begin
            n_fail++;
            $display("FAIL post_reset_idle: got busy=%b starts=%0d, expected 0 0", BUSY, n_starts - base_n);
        end
        exp_q.push_back(28'h0001000);
        start_session(28'h0001000, 28'h100, 5'd4);
        for (int i = 0; i < 10; i++) begin
            step(0, 0);
            if (n_starts - base_n >= 1) break;
        end
        ENABLE = 1'b0;
        n_tests++;
        if (n_starts - base_n !== 1) begin
            n_fail++;
            $display("FAIL post_reset_restart: got %0d starts, expected 1", n_starts - base_n);
        end
        DMA_DONE_CNT = DMA_DONE_CNT + 16'd1;
        wait_idle(0, 0);
    endtask

    initial begin
        test_reset();
        test_basic_ring();
        test_ring_full();
        test_wrap_burst();
        test_clamp_drain();
        test_async_reset();
        n_tests++;
        if (exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL scoreboard_leftover: got %0d pending, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "timeout");
    end

endmodule
